// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types and constants
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] fixed16_t;

    typedef enum logic [1:0] {
        IDLE,
        LOADW,
        STREAM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - left/top edge bus from feeder into the 2x2 systolic array
interface systolic_feeder_if #(
    parameter int DATA_W = tpu_pkg::DATA_W
);

    logic [DATA_W-1:0] sys_data_in_11;
    logic [DATA_W-1:0] sys_data_in_21;
    logic              sys_start;
    logic [DATA_W-1:0] sys_weight_in_11;
    logic [DATA_W-1:0] sys_weight_in_12;
    logic              sys_accept_w_1;
    logic              sys_accept_w_2;
    logic              sys_switch_in;

    modport master (
        output sys_data_in_11,
        output sys_data_in_21,
        output sys_start,
        output sys_weight_in_11,
        output sys_weight_in_12,
        output sys_accept_w_1,
        output sys_accept_w_2,
        output sys_switch_in
    );

    modport slave (
        input sys_data_in_11,
        input sys_data_in_21,
        input sys_start,
        input sys_weight_in_11,
        input sys_weight_in_12,
        input sys_accept_w_1,
        input sys_accept_w_2,
        input sys_switch_in
    );

endinterface

// File: rtl/feeder_rowbuf.sv
// rtl/feeder_rowbuf.sv - activation row buffer, one write port, two registered read ports
module feeder_rowbuf #(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic                rd1_en,
    input  logic [AW-1:0]       rd1_addr,
    output logic [DATA_W-1:0]   rd1_col0,
    input  logic                rd2_en,
    input  logic [AW-1:0]       rd2_addr,
    output logic [DATA_W-1:0]   rd2_col1
);

    // Rows are stored as {A[r][1], A[r][0]}; port 1 feeds array row 1 (column 0),
    // port 2 feeds array row 2 (column 1), so each port returns only its half.
    logic [2*DATA_W-1:0] mem [DEPTH];

    // Storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered reads; a disabled port drives 0 so the array edge sees zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_col0 <= '0;
            rd2_col1 <= '0;
        end else begin
            rd1_col0 <= rd1_en ? mem[rd1_addr][DATA_W-1:0]        : '0;
            rd2_col1 <= rd2_en ? mem[rd2_addr][2*DATA_W-1:DATA_W] : '0;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - weight preload and skewed activation feeder for the 2x2 systolic array
module systolic_feeder
    import tpu_pkg::feeder_state_t, tpu_pkg::IDLE, tpu_pkg::LOADW, tpu_pkg::STREAM, tpu_pkg::DONE;
#(
    parameter int  DATA_W   = tpu_pkg::DATA_W,
    parameter int  MAX_ROWS = 16,
    localparam int AW       = $clog2(MAX_ROWS),
    localparam int CW       = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_wr_en,
    input  logic [1:0]          w_wr_addr,
    input  logic [DATA_W-1:0]   w_wr_data,
    input  logic                a_wr_en,
    input  logic [AW-1:0]       a_wr_addr,
    input  logic [2*DATA_W-1:0] a_wr_data,
    input  logic                start,
    input  logic [CW-1:0]       num_rows,
    output logic                busy,
    output logic                done,
    systolic_feeder_if.master   sys
);

    feeder_state_t     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     n_q, n_d;
    logic [DATA_W-1:0] w_q   [4];
    logic [DATA_W-1:0] w_fwd [4];

    logic              wr_ok;
    logic              launch;

    logic              busy_d, done_d;
    logic [DATA_W-1:0] w11_d, w12_d, w11_q, w12_q;
    logic              acc1_d, acc2_d, sw_d, st_d;
    logic              acc1_q, acc2_q, sw_q, st_q;

    logic              rd1_en, rd2_en;
    logic [AW-1:0]     rd1_addr, rd2_addr;
    logic [DATA_W-1:0] rd1_col0, rd2_col1;

    assign wr_ok  = (state_q == IDLE);
    assign launch = wr_ok && start && (num_rows != '0) && (num_rows <= CW'(MAX_ROWS));

    // A weight written in the launch cycle must reach L0 on the next edge, so
    // the output mux sees the pending write rather than the stale register.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_fwd[i] = w_q[i];
        end
        if (w_wr_en && wr_ok) begin
            w_fwd[w_wr_addr] = w_wr_data;
        end
    end

    // 2x2 weight registers, indexed by {row,col}; host writes only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
            end
        end else if (w_wr_en && wr_ok) begin
            w_q[w_wr_addr] <= w_wr_data;
        end
    end

    // Next state/count, and the edge outputs for the phase being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        w11_d    = '0;
        w12_d    = '0;
        acc1_d   = 1'b0;
        acc2_d   = 1'b0;
        sw_d     = 1'b0;
        st_d     = 1'b0;
        rd1_en   = 1'b0;
        rd2_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LOADW;
                    cnt_d   = '0;
                    n_d     = num_rows;
                end
            end
            LOADW: begin
                if (cnt_q == CW'(1)) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_q == n_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Columns shift downwards, so the bottom-row weight goes in first.
        if (state_d == LOADW) begin
            acc1_d = 1'b1;
            if (cnt_d == '0) begin
                w11_d = w_fwd[2];
            end else begin
                w11_d  = w_fwd[0];
                w12_d  = w_fwd[3];
                acc2_d = 1'b1;
            end
        end
        if (state_d == STREAM) begin
            rd1_en = (cnt_d < n_d);
            rd2_en = (cnt_d != '0);
            if (cnt_d == '0) begin
                w12_d  = w_fwd[1];
                acc2_d = 1'b1;
                sw_d   = 1'b1;
                st_d   = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign rd1_addr = cnt_d[AW-1:0];
    assign rd2_addr = AW'(cnt_d - 1'b1);

    // State, counter and registered edge outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w11_q   <= '0;
            w12_q   <= '0;
            acc1_q  <= 1'b0;
            acc2_q  <= 1'b0;
            sw_q    <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            busy    <= busy_d;
            done    <= done_d;
            w11_q   <= w11_d;
            w12_q   <= w12_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            sw_q    <= sw_d;
            st_q    <= st_d;
        end
    end

    feeder_rowbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_ROWS)
    ) u_rowbuf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (a_wr_en && wr_ok),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .rd1_en   (rd1_en),
        .rd1_addr (rd1_addr),
        .rd1_col0 (rd1_col0),
        .rd2_en   (rd2_en),
        .rd2_addr (rd2_addr),
        .rd2_col1 (rd2_col1)
    );

    assign sys.sys_data_in_11   = rd1_col0;
    assign sys.sys_data_in_21   = rd2_col1;
    assign sys.sys_start        = st_q;
    assign sys.sys_weight_in_11 = w11_q;
    assign sys.sys_weight_in_12 = w12_q;
    assign sys.sys_accept_w_1   = acc1_q;
    assign sys.sys_accept_w_2   = acc2_q;
    assign sys.sys_switch_in    = sw_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;
    import tpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_wr_en;
    logic [1:0] w_wr_addr;
    fixed16_t   w_wr_data;
    logic       a_wr_en;
    logic [3:0] a_wr_addr;
    logic [31:0] a_wr_data;
    logic       start;
    logic [4:0] num_rows;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    logic [79:0] exp_q [$];
    logic [79:0] obs_vec;

    systolic_feeder_if #(.DATA_W(16)) sys ();

    systolic_feeder #(
        .DATA_W   (16),
        .MAX_ROWS (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_wr_en   (w_wr_en),
        .w_wr_addr (w_wr_addr),
        .w_wr_data (w_wr_data),
        .a_wr_en   (a_wr_en),
        .a_wr_addr (a_wr_addr),
        .a_wr_data (a_wr_data),
        .start     (start),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .sys       (sys)
    );

    always #5 clk = ~clk;

    assign obs_vec = {10'b0, busy, done, sys.sys_data_in_11, sys.sys_data_in_21, sys.sys_start,
                      sys.sys_weight_in_11, sys.sys_weight_in_12, sys.sys_accept_w_1,
                      sys.sys_accept_w_2, sys.sys_switch_in};

    function automatic logic [79:0] ev(input logic b, input logic d,
                                       input logic [15:0] d11, input logic [15:0] d21,
                                       input logic st, input logic [15:0] w11,
                                       input logic [15:0] w12, input logic a1,
                                       input logic a2, input logic sw);
        return {10'b0, b, d, d11, d21, st, w11, w12, a1, a2, sw};
    endfunction

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr_w(input logic [1:0] addr, input logic [15:0] data);
        w_wr_en = 1'b1; w_wr_addr = addr; w_wr_data = data;
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [31:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        start = 1'b1; num_rows = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks the queued cycles back to back; the first entry is the current cycle.
    // At index inj a stray start and weight write are driven for one cycle.
    task automatic run_q(input string tag, input int inj);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("%s[%0d]", tag, i), obs_vec, exp_q[i]);
            if (i == inj) begin
                start = 1'b1; num_rows = 5'd2;
                w_wr_en = 1'b1; w_wr_addr = 2'd2; w_wr_data = 16'h7FFF;
            end
            if (i == inj + 1) begin
                start = 1'b0; w_wr_en = 1'b0;
            end
        end
        exp_q.delete();
    endtask

    task automatic q_n1(input logic [15:0] a00, input logic [15:0] a01,
                        input logic [15:0] w10, input logic [15:0] w00,
                        input logic [15:0] w11);
        exp_q.push_back(ev(1, 0, 0, 0, 0, w10, 0, 1, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, w00, w11, 1, 1, 0));
        exp_q.push_back(ev(1, 0, a00, 0, 1, 0, 0, 0, 1, 1));
        exp_q.push_back(ev(1, 0, 0, a01, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0;
        a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; start = 0; num_rows = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", obs_vec, 80'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_after_reset", obs_vec, 80'h0);

        // Identity weights, A = {{1,2},{3,4}}, N=2
        wr_w(2'd0, 16'h0100); wr_w(2'd1, 16'h0000);
        wr_w(2'd2, 16'h0000); wr_w(2'd3, 16'h0100);
        wr_a(4'd0, {16'h0200, 16'h0100});
        wr_a(4'd1, {16'h0400, 16'h0300});
        pulse_start(5'd2);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0100, 16'h0100, 1, 1, 0));
        exp_q.push_back(ev(1, 0, 16'h0100, 0, 1, 0, 16'h0000, 0, 1, 1));
        exp_q.push_back(ev(1, 0, 16'h0300, 16'h0200, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 16'h0400, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_q("n2", -1);

        // N=1, A[0] = {2.0, 0.5}
        wr_a(4'd0, {16'h0080, 16'h0200});
        pulse_start(5'd1);
        q_n1(16'h0200, 16'h0080, 16'h0000, 16'h0100, 16'h0100);
        run_q("n1", -1);

        // Illegal N values leave the block idle
        pulse_start(5'd0);
        for (int i = 0; i < 3; i++) check_eq($sformatf("n0_idle[%0d]", i), obs_vec, 80'h0);
        pulse_start(5'd17);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("n17_idle[%0d]", i), obs_vec, 80'h0);
            @(negedge clk);
        end

        // Stray start and weight write during STREAM are ignored
        pulse_start(5'd2);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0100, 16'h0100, 1, 1, 0));
        exp_q.push_back(ev(1, 0, 16'h0200, 0, 1, 0, 0, 0, 1, 1));
        exp_q.push_back(ev(1, 0, 16'h0300, 16'h0080, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 16'h0400, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_q("midrun", 2);
        pulse_start(5'd1);
        q_n1(16'h0200, 16'h0080, 16'h0000, 16'h0100, 16'h0100);
        run_q("after_midrun", -1);

        // Reset in S1
        pulse_start(5'd2);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0100, 16'h0100, 1, 1, 0));
        exp_q.push_back(ev(1, 0, 16'h0200, 0, 1, 0, 0, 0, 1, 1));
        exp_q.push_back(ev(1, 0, 16'h0300, 16'h0080, 0, 0, 0, 0, 0, 0));
        run_q("pre_rst", -1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_run", obs_vec, 80'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_no_done", obs_vec, 80'h0);
        wr_a(4'd0, {16'h0011, 16'h0022});
        pulse_start(5'd1);
        q_n1(16'h0022, 16'h0011, 16'h0000, 16'h0000, 16'h0000);
        run_q("post_rst", -1);

        // N=MAX_ROWS with a weight written in the launch cycle
        for (int r = 0; r < 16; r++) wr_a(4'(r), {16'(r + 256), 16'(r)});
        w_wr_en = 1'b1; w_wr_addr = 2'd2; w_wr_data = 16'h1234;
        start = 1'b1; num_rows = 5'd16;
        @(negedge clk);
        w_wr_en = 1'b0; start = 1'b0;
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h1234, 0, 1, 0, 0));
        exp_q.push_back(ev(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0));
        for (int k = 0; k <= 16; k++) begin
            exp_q.push_back(ev(1, 0, (k < 16) ? 16'(k) : 16'h0,
                               (k >= 1) ? 16'(k - 1 + 256) : 16'h0,
                               k == 0, 16'h0, 16'h0, 1'b0, k == 0, k == 0));
        end
        exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_q("nmax", -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
